// File: rtl/io_port_pkg.sv
// Shared definitions for the memory-mapped I/O port controller.
// Holds the register offsets seen on the CPU bus (word offset, bus addr[3:2])
// and the reset values of the port state bits.
package io_port_pkg;

  // Register map. All four codes are used, so the 2-bit address is fully decoded.
  typedef enum logic [1:0] {
    IO_DATA    = 2'd0,
    IO_DIR     = 2'd1,
    IO_IRQEN   = 2'd2,
    IO_IRQFLAG = 2'd3
  } io_reg_e;

  // Per-bit reset values. Every pin comes up as an undriven input with
  // interrupts disabled and no pending flags.
  localparam logic IO_OUT_RST_BIT   = 1'b0;
  localparam logic IO_DIR_RST_BIT   = 1'b0;
  localparam logic IO_IRQEN_RST_BIT = 1'b0;
  localparam logic IO_FLAG_RST_BIT  = 1'b0;

endpackage

// File: rtl/io_sync.sv
// Input synchroniser for the port pads.
// A SYNC_STAGES-deep flop chain brings the asynchronous pad levels into the
// sys_clk domain; a further register keeps the previous synchronised sample so
// that any edge (rising or falling) shows up as a one-cycle toggle pulse.
// Ports:
//   sys_clk  in   system clock
//   rst_n    in   asynchronous active-low reset
//   pad      in   raw pad levels
//   sync_in  out  synchronised pad levels
//   toggle   out  sync_in differs from the previous sample
module io_sync
  import io_port_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] toggle
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic [WIDTH-1:0] prev_in;

  // prev_in also clears on reset, so a pin already high when reset is
  // released produces one toggle pulse once it reaches the end of the chain.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stage[s] <= '0;
      end
      prev_in <= '0;
    end else begin
      stage[0] <= pad;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        stage[s] <= stage[s-1];
      end
      prev_in <= sync_in;
    end
  end

  assign sync_in = stage[SYNC_STAGES-1];
  assign toggle  = sync_in ^ prev_in;

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped controller for the bidirectional port pins.
// Holds the output latch, per-bit direction, change-interrupt enables and
// change flags; drives the pads and raises a level interrupt to the CPU.
// Ports:
//   sys_clk   in     system clock, all state on rising edge
//   rst_n     in     asynchronous active-low reset
//   ce        in     chip enable from the address decoder
//   wr        in     1 = write, 0 = read (while ce = 1)
//   addr      in     register select: DATA, DIR, IRQ_EN, IRQ_FLAG
//   data_in   in     write data from the CPU
//   data_out  out    read data to the CPU (combinational, 0 when not reading)
//   irq       out    registered level interrupt request
//   port_io   inout  pads
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             wr,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             irq,
  inout  wire  [WIDTH-1:0] port_io
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_flag;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] change;
  logic [WIDTH-1:0] clr;
  logic             wr_data;
  logic             wr_dir;
  logic             wr_irqen;
  logic             wr_flag;
  io_reg_e          reg_sel;

  assign reg_sel = io_reg_e'(addr);

  // Write strobes, one per register.
  always_comb begin
    wr_data  = 1'b0;
    wr_dir   = 1'b0;
    wr_irqen = 1'b0;
    wr_flag  = 1'b0;
    if (ce && wr) begin
      unique case (reg_sel)
        IO_DATA:    wr_data  = 1'b1;
        IO_DIR:     wr_dir   = 1'b1;
        IO_IRQEN:   wr_irqen = 1'b1;
        IO_IRQFLAG: wr_flag  = 1'b1;
      endcase
    end
  end

  io_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .pad     (port_io),
    .sync_in (sync_in),
    .toggle  (toggle)
  );

  // Pins we drive ourselves never report a change, including on the very edge
  // where DIR switches them to output.
  assign change = toggle & ~dir_reg;
  assign clr    = wr_flag ? data_in : '0;

  // Register file and interrupt. A new change on a bit wins over a
  // simultaneous write-1-to-clear, so no event is lost. irq is computed from
  // the registered flags/enables, so it follows them by one cycle.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= {WIDTH{IO_OUT_RST_BIT}};
      dir_reg  <= {WIDTH{IO_DIR_RST_BIT}};
      irq_en   <= {WIDTH{IO_IRQEN_RST_BIT}};
      irq_flag <= {WIDTH{IO_FLAG_RST_BIT}};
      irq      <= 1'b0;
    end else begin
      if (wr_data)  out_reg <= data_in;
      if (wr_dir)   dir_reg <= data_in;
      if (wr_irqen) irq_en  <= data_in;
      irq_flag <= change | (irq_flag & ~clr);
      irq      <= |(irq_flag & irq_en);
    end
  end

  // Same-cycle read path for the single-cycle CPU. DATA reads back the latch
  // on output pins and the synchronised pad on input pins.
  always_comb begin
    data_out = '0;
    if (ce && !wr) begin
      unique case (reg_sel)
        IO_DATA:    data_out = (dir_reg & out_reg) | (~dir_reg & sync_in);
        IO_DIR:     data_out = dir_reg;
        IO_IRQEN:   data_out = irq_en;
        IO_IRQFLAG: data_out = irq_flag;
      endcase
    end
  end

  // Pad drivers, straight from the registers so a DATA write shows on the pad
  // right after its clock edge.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign port_io[i] = dir_reg[i] ? out_reg[i] : 1'bz;
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: register read/write table followed
// by hand-written sequences for synchroniser latency, interrupt flags,
// write-1-to-clear, set-beats-clear, output masking and asynchronous reset.
module tb_io_port_ctrl;
  import io_port_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b1;
  logic        ce      = 1'b0;
  logic        wr      = 1'b0;
  logic [1:0]  addr    = 2'd0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        irq;
  wire  [31:0] port_io;

  // Bench-side pad drivers: drv_en selects which pins the bench drives.
  logic [31:0] drv_en  = '0;
  logic [31:0] drv_val = '0;

  int checks   = 0;
  int failures = 0;

  for (genvar i = 0; i < 32; i++) begin : g_drv
    assign port_io[i] = drv_en[i] ? drv_val[i] : 1'bz;
  end

  io_port_ctrl #(
    .WIDTH       (32),
    .SYNC_STAGES (2)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq),
    .port_io  (port_io)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Bus write: strobes ce/wr across one rising edge.
  task automatic apply_stimulus(input logic [1:0] a, input logic [31:0] d);
    ce      = 1'b1;
    wr      = 1'b1;
    addr    = a;
    data_in = d;
    tick();
    ce      = 1'b0;
    wr      = 1'b0;
    data_in = '0;
  endtask

  task automatic check_read(input string name, input logic [1:0] a,
                            input logic [31:0] expected);
    ce   = 1'b1;
    wr   = 1'b0;
    addr = a;
    #1;
    check_output(name, data_out, expected);
    ce   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Bits that currently resolve to a strong 1 on the pads.
  function automatic logic [31:0] pads_high();
    logic [31:0] h;
    for (int i = 0; i < 32; i++) h[i] = (port_io[i] === 1'b1);
    return h;
  endfunction

  initial begin
    vecs[0] = '{"tbl_dir_all_out", IO_DIR,   32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[1] = '{"tbl_data_1",      IO_DATA,  32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{"tbl_data_0",      IO_DATA,  32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{"tbl_data_2",      IO_DATA,  32'hFFFF_0000, 32'hFFFF_0000};
    vecs[4] = '{"tbl_irqen_1",     IO_IRQEN, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
    vecs[5] = '{"tbl_irqen_0",     IO_IRQEN, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{"tbl_dir_mix",     IO_DIR,   32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[7] = '{"tbl_dir_all_out2",IO_DIR,   32'hFFFF_FFFF, 32'hFFFF_FFFF};

    // Power-on reset.
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_irq", {31'b0, irq}, 32'h0);
    check_output("rst_dout_ce0", data_out, 32'h0);
    check_read("rst_dir", IO_DIR, 32'h0);
    ticks(2);
    rst_n = 1'b1;
    tick();

    // Register write/readback table.
    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].addr, vecs[v].wdata);
      check_read(vecs[v].name, vecs[v].addr, vecs[v].exp);
    end
    check_output("tbl_pads", port_io, 32'hFFFF_0000);
    ce = 1'b1; wr = 1'b1; addr = IO_DIR; #1;
    check_output("dout_on_write", data_out, 32'h0);
    ce = 1'b0; wr = 1'b0;
    tick();

    // Low byte output, bench drives the upper pins.
    apply_stimulus(IO_DIR, 32'h0000_00FF);
    drv_en  = 32'hFFFF_FF00;
    drv_val = 32'h1234_5600;
    apply_stimulus(IO_DATA, 32'hA5A5_A5A5);
    check_output("pad_low_byte", {24'h0, port_io[7:0]}, 32'h0000_00A5);
    check_read("data_sync_1clk", IO_DATA, 32'hFFFF_00A5);
    tick();
    check_read("data_sync_2clk", IO_DATA, 32'h1234_56A5);
    ticks(2);
    apply_stimulus(IO_IRQFLAG, 32'hFFFF_FFFF);
    check_read("flags_cleared", IO_IRQFLAG, 32'h0);

    // Pin-to-flag and pin-to-irq latency on pad 8.
    apply_stimulus(IO_IRQEN, 32'h0000_0100);
    drv_val = 32'h1234_5700;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_read($sformatf("lat_flag_%0d", k), IO_IRQFLAG,
                 (k >= 3) ? 32'h0000_0100 : 32'h0);
      check_output($sformatf("lat_irq_%0d", k), {31'b0, irq},
                   (k >= 4) ? 32'h1 : 32'h0);
    end

    // Write-1-to-clear, then write of zero leaves flags alone.
    apply_stimulus(IO_IRQFLAG, 32'h0000_0100);
    check_read("w1c_flag", IO_IRQFLAG, 32'h0);
    check_output("w1c_irq_lag", {31'b0, irq}, 32'h1);
    tick();
    check_output("w1c_irq_drop", {31'b0, irq}, 32'h0);
    drv_val = 32'h1234_5600;
    ticks(4);
    check_read("fall_flag", IO_IRQFLAG, 32'h0000_0100);
    apply_stimulus(IO_IRQFLAG, 32'h0);
    check_read("w0_flag", IO_IRQFLAG, 32'h0000_0100);
    tick();
    check_output("w0_irq", {31'b0, irq}, 32'h1);

    // Change and clear on the same edge: the change wins.
    drv_val = 32'h1234_5700;
    ticks(2);
    apply_stimulus(IO_IRQFLAG, 32'h0000_0100);
    check_read("setwin_flag", IO_IRQFLAG, 32'h0000_0100);
    check_output("setwin_irq", {31'b0, irq}, 32'h1);
    apply_stimulus(IO_IRQFLAG, 32'h0000_0100);
    check_read("setwin_clr_after", IO_IRQFLAG, 32'h0);
    tick();
    check_output("setwin_irq_drop", {31'b0, irq}, 32'h0);

    // Output pins never flag, including across a 1->0 DIR change.
    apply_stimulus(IO_DATA, 32'hA5A5_A5AD);
    check_output("pad_bit3", {24'h0, port_io[7:0]}, 32'h0000_00AD);
    ticks(4);
    check_read("out_no_flag", IO_IRQFLAG, 32'h0);
    drv_en  = 32'hFFFF_FF08;
    drv_val = 32'h1234_5708;
    apply_stimulus(IO_DIR, 32'h0000_00F7);
    ticks(4);
    check_read("dir_to_in_no_flag", IO_IRQFLAG, 32'h0);

    // Pending flag on pad 5, then enable everything.
    drv_en  = 32'hFFFF_FF28;
    drv_val = 32'h1234_5728;
    apply_stimulus(IO_DIR, 32'h0000_00D7);
    tick();
    drv_val = 32'h1234_5708;
    ticks(4);
    check_read("bit5_flag", IO_IRQFLAG, 32'h0000_0020);
    check_read("mixed_data", IO_DATA, 32'h1234_578D);
    check_output("bit5_irq_masked", {31'b0, irq}, 32'h0);
    apply_stimulus(IO_IRQEN, 32'hFFFF_FFFF);
    check_output("en_irq_lag", {31'b0, irq}, 32'h0);
    tick();
    check_output("en_irq_rise", {31'b0, irq}, 32'h1);

    // All outputs high, then asynchronous reset mid-cycle.
    drv_en = '0;
    apply_stimulus(IO_DIR, 32'hFFFF_FFFF);
    apply_stimulus(IO_DATA, 32'hFFFF_FFFF);
    check_output("pads_all_high", pads_high(), 32'hFFFF_FFFF);
    check_output("pre_rst_irq", {31'b0, irq}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check_output("async_rst_irq", {31'b0, irq}, 32'h0);
    check_output("async_rst_pads", pads_high(), 32'h0);
    check_read("async_rst_dir", IO_DIR, 32'h0);
    check_read("async_rst_irqen", IO_IRQEN, 32'h0);
    check_read("async_rst_flag", IO_IRQFLAG, 32'h0);
    check_read("async_rst_data", IO_DATA, 32'h0);
    ticks(2);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
